// File: rtl/pe_mac_sequencer_if.sv
// ---------------------------------------------------------------------------
// pe_mac_sequencer_if
// Bundles the handshake, configuration and datapath-control signals that
// run between the PE config/handshake logic, the pe_mac_sequencer and the
// spad + multiplier + adder datapath.
//
//   start        master->slave  begin a pass (taken only while idle)
//   cfg_s/q/p    master->slave  taps S, channels q, filters p
//   ifmap_valid  master->slave  ifmap spad holds the current window
//   stall        master->slave  freeze operand issue
//   filt_addr    slave->master  filter spad read address
//   ifmap_addr   slave->master  ifmap spad read address
//   mult_enable  slave->master  multiplier enable for the issued pair
//   acc_we       slave->master  accumulate product into psum spad
//   acc_addr     slave->master  psum entry to accumulate
//   acc_clear    slave->master  write the product alone (first term)
//   busy         slave->master  sequencer is not idle
//   done         slave->master  one-cycle end-of-pass pulse
//   cfg_err      slave->master  one-cycle pulse with done on a bad config
// ---------------------------------------------------------------------------
interface pe_mac_sequencer_if #(
    parameter int FILT_ADDR_W  = 8,
    parameter int IFMAP_ADDR_W = 4,
    parameter int PSUM_ADDR_W  = 5,
    parameter int CNT_W        = 5
) ();
    logic                    start;
    logic [CNT_W-1:0]        cfg_s;
    logic [CNT_W-1:0]        cfg_q;
    logic [CNT_W-1:0]        cfg_p;
    logic                    ifmap_valid;
    logic                    stall;
    logic [FILT_ADDR_W-1:0]  filt_addr;
    logic [IFMAP_ADDR_W-1:0] ifmap_addr;
    logic                    mult_enable;
    logic                    acc_we;
    logic [PSUM_ADDR_W-1:0]  acc_addr;
    logic                    acc_clear;
    logic                    busy;
    logic                    done;
    logic                    cfg_err;

    modport master (
        output start, cfg_s, cfg_q, cfg_p, ifmap_valid, stall,
        input  filt_addr, ifmap_addr, mult_enable, acc_we, acc_addr, acc_clear,
               busy, done, cfg_err
    );

    modport slave (
        input  start, cfg_s, cfg_q, cfg_p, ifmap_valid, stall,
        output filt_addr, ifmap_addr, mult_enable, acc_we, acc_addr, acc_clear,
               busy, done, cfg_err
    );
endinterface

// File: rtl/pe_mac_sequencer.sv
// ---------------------------------------------------------------------------
// pe_mac_sequencer
// Per-PE controller that walks one sliding-window pass of S taps x q
// channels x p filters. Each RUN cycle it issues one filter/ifmap operand
// pair to the multiplier; one cycle later it issues the matching psum
// accumulate (the multiplier captures on negedge, so its product is stable
// at the posedge following mult_enable).
//
// Ports:
//   clk    clock, all state updates on posedge
//   reset  asynchronous active-high reset, clears all state
//   bus    pe_mac_sequencer_if.slave (start/cfg/ifmap_valid/stall in;
//          spad addresses, mult_enable, acc_* controls, busy/done/cfg_err out)
// ---------------------------------------------------------------------------
module pe_mac_sequencer #(
    parameter int FILT_ADDR_W  = 8,
    parameter int IFMAP_ADDR_W = 4,
    parameter int PSUM_ADDR_W  = 5,
    parameter int CNT_W        = 5
) (
    input  logic              clk,
    input  logic              reset,
    pe_mac_sequencer_if.slave bus
);
    localparam int unsigned FILT_DEPTH  = 1 << FILT_ADDR_W;
    localparam int unsigned IFMAP_DEPTH = 1 << IFMAP_ADDR_W;
    localparam int unsigned PSUM_DEPTH  = 1 << PSUM_ADDR_W;
    localparam int          PROD_W      = 3 * CNT_W;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IFMAP,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t state, state_nx;

    // Configuration latched at start
    logic [CNT_W-1:0]        cfg_s_r, cfg_q_r, cfg_p_r;
    logic                    cfg_err_r;

    // Loop counters: f innermost, then c, then s
    logic [CNT_W-1:0]        f_cnt, c_cnt, s_cnt;
    logic [FILT_ADDR_W-1:0]  op_cnt;
    logic [IFMAP_ADDR_W-1:0] win_cnt;

    logic [2*CNT_W-1:0]      prod_sq;
    logic [PROD_W-1:0]       prod_sqp;
    logic                    cfg_legal;

    logic                    f_last, c_last, s_last, last_op;
    logic                    mult_en_p0;
    logic                    clear_p0;

    logic                    acc_we_p1;
    logic [PSUM_ADDR_W-1:0]  acc_addr_p1;
    logic                    acc_clear_p1;

    // Legality is judged on the live cfg inputs, since it is only used in
    // the IDLE cycle that latches them.
    always_comb begin
        prod_sq   = {{CNT_W{1'b0}}, bus.cfg_s} * {{CNT_W{1'b0}}, bus.cfg_q};
        prod_sqp  = {{CNT_W{1'b0}}, prod_sq} * {{(2*CNT_W){1'b0}}, bus.cfg_p};
        cfg_legal = (bus.cfg_s != '0) && (bus.cfg_q != '0) && (bus.cfg_p != '0)
                 && (32'(prod_sqp)  <= FILT_DEPTH)
                 && (32'(prod_sq)   <= IFMAP_DEPTH)
                 && (32'(bus.cfg_p) <= PSUM_DEPTH);
    end

    assign f_last   = (f_cnt == cfg_p_r - CNT_W'(1));
    assign c_last   = (c_cnt == cfg_q_r - CNT_W'(1));
    assign s_last   = (s_cnt == cfg_s_r - CNT_W'(1));
    assign last_op  = f_last && c_last && s_last;
    assign clear_p0 = (s_cnt == '0) && (c_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        mult_en_p0 = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = cfg_legal ? WAIT_IFMAP : DONE;
                end
            end
            WAIT_IFMAP: begin
                if (bus.ifmap_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    mult_en_p0 = 1'b1;
                    if (last_op) begin
                        state_nx = FLUSH;
                    end
                end
            end
            FLUSH:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Stage p0: operand issue. Counters advance only on an issued op and
    // all return to zero after the last one, so addresses read 0 outside RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_s_r   <= '0;
            cfg_q_r   <= '0;
            cfg_p_r   <= '0;
            cfg_err_r <= 1'b0;
            f_cnt     <= '0;
            c_cnt     <= '0;
            s_cnt     <= '0;
            op_cnt    <= '0;
            win_cnt   <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                cfg_s_r   <= bus.cfg_s;
                cfg_q_r   <= bus.cfg_q;
                cfg_p_r   <= bus.cfg_p;
                cfg_err_r <= !cfg_legal;
            end else if (state == DONE) begin
                cfg_err_r <= 1'b0;
            end

            if (mult_en_p0) begin
                if (last_op) begin
                    f_cnt   <= '0;
                    c_cnt   <= '0;
                    s_cnt   <= '0;
                    op_cnt  <= '0;
                    win_cnt <= '0;
                end else begin
                    op_cnt <= op_cnt + FILT_ADDR_W'(1);
                    if (f_last) begin
                        f_cnt   <= '0;
                        // window index s*q+c is linear, so a plain increment
                        // covers both the c step and the c-wrap/s step
                        win_cnt <= win_cnt + IFMAP_ADDR_W'(1);
                        if (c_last) begin
                            c_cnt <= '0;
                            s_cnt <= s_cnt + CNT_W'(1);
                        end else begin
                            c_cnt <= c_cnt + CNT_W'(1);
                        end
                    end else begin
                        f_cnt <= f_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Stage p1: accumulate controls, one cycle behind issue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_we_p1    <= 1'b0;
            acc_addr_p1  <= '0;
            acc_clear_p1 <= 1'b0;
        end else begin
            acc_we_p1    <= mult_en_p0;
            acc_addr_p1  <= mult_en_p0 ? PSUM_ADDR_W'(f_cnt) : '0;
            acc_clear_p1 <= mult_en_p0 && clear_p0;
        end
    end

    assign bus.filt_addr   = op_cnt;
    assign bus.ifmap_addr  = win_cnt;
    assign bus.mult_enable = mult_en_p0;
    assign bus.acc_we      = acc_we_p1;
    assign bus.acc_addr    = acc_addr_p1;
    assign bus.acc_clear   = acc_clear_p1;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.cfg_err     = (state == DONE) && cfg_err_r;

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pe_mac_sequencer
// Directed bench for pe_mac_sequencer. Inputs change on the falling edge;
// outputs are sampled 1 time unit later, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_pe_mac_sequencer;
    localparam int FA = 8;
    localparam int IA = 4;
    localparam int PA = 5;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pe_mac_sequencer_if #(
        .FILT_ADDR_W(FA), .IFMAP_ADDR_W(IA), .PSUM_ADDR_W(PA), .CNT_W(CW)
    ) bus ();

    pe_mac_sequencer #(
        .FILT_ADDR_W(FA), .IFMAP_ADDR_W(IA), .PSUM_ADDR_W(PA), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // One full legal pass. Starts from an IDLE cycle, ends after the DONE
    // cycle. stall_at/stall_len insert a stall at an op index (-1: none),
    // start_run_at pulses start during RUN at an op index (-1: none).
    task automatic drive_pass(input int s, input int q, input int p,
                              input int stall_at, input int stall_len,
                              input int wait_cyc, input int start_run_at,
                              input bit start_in_done);
        int              n, op, run_cyc, stall_left;
        bit              stl, pulsed;
        logic            prev_en, prev_clr;
        logic [PA-1:0]   prev_f;
        logic [FA+IA:0]  exp_issue;
        logic [PA+1:0]   exp_acc;
        n = s * q * p;

        @(negedge clk);
        bus.start       = 1'b1;
        bus.cfg_s       = CW'(s);
        bus.cfg_q       = CW'(q);
        bus.cfg_p       = CW'(p);
        bus.ifmap_valid = (wait_cyc == 0);
        bus.stall       = 1'b0;
        #1;
        chk_cnt++;
        if (bus.busy !== 1'b0)
            $display("FAIL idle_at_start busy=%0b want 0", bus.busy);
        else pass_cnt++;

        for (int w = 0; w <= wait_cyc; w++) begin
            @(negedge clk);
            bus.start       = 1'b0;
            bus.ifmap_valid = (w == wait_cyc);
            #1;
            chk_cnt++;
            if ({bus.busy, bus.mult_enable, bus.acc_we} !== 3'b100)
                $display("FAIL wait_ifmap w=%0d busy/men/we=%b want 100", w,
                         {bus.busy, bus.mult_enable, bus.acc_we});
            else pass_cnt++;
        end

        op = 0; run_cyc = 0; stall_left = stall_len; pulsed = 1'b0;
        prev_en = 1'b0; prev_clr = 1'b0; prev_f = '0;
        while (op < n && run_cyc < n + stall_len + 4) begin
            @(negedge clk);
            stl             = (op == stall_at) && (stall_left > 0);
            bus.stall       = stl;
            bus.ifmap_valid = 1'b0;
            bus.start       = (op == start_run_at) && !pulsed;
            if (bus.start) pulsed = 1'b1;
            #1;
            exp_issue = {~stl, FA'(op), IA'(op / p)};
            exp_acc   = prev_en ? {1'b1, prev_f, prev_clr} : '0;
            chk_cnt++;
            if ({bus.mult_enable, bus.filt_addr, bus.ifmap_addr} !== exp_issue)
                $display("FAIL issue op=%0d men/filt/ifm=%h want %h", op,
                         {bus.mult_enable, bus.filt_addr, bus.ifmap_addr}, exp_issue);
            else pass_cnt++;
            chk_cnt++;
            if ({bus.acc_we, bus.acc_addr, bus.acc_clear} !== exp_acc)
                $display("FAIL acc op=%0d we/addr/clr=%h want %h", op,
                         {bus.acc_we, bus.acc_addr, bus.acc_clear}, exp_acc);
            else pass_cnt++;
            chk_cnt++;
            if ({bus.busy, bus.done} !== 2'b10)
                $display("FAIL run_ctl op=%0d busy/done=%b want 10", op,
                         {bus.busy, bus.done});
            else pass_cnt++;
            prev_en = ~stl;
            if (!stl) begin
                prev_f   = PA'(op % p);
                prev_clr = (op < p);
                op++;
            end else begin
                stall_left--;
            end
            run_cyc++;
        end
        chk_cnt++;
        if (run_cyc !== n + stall_len || op !== n)
            $display("FAIL run_length cycles=%0d ops=%0d want %0d/%0d", run_cyc, op,
                     n + stall_len, n);
        else pass_cnt++;

        // FLUSH: stall must not hold the final accumulate back
        @(negedge clk);
        bus.stall = 1'b1;
        bus.start = 1'b0;
        #1;
        exp_acc = {1'b1, prev_f, prev_clr};
        chk_cnt++;
        if ({bus.mult_enable, bus.acc_we, bus.acc_addr, bus.acc_clear} !== {1'b0, exp_acc})
            $display("FAIL flush men/we/addr/clr=%h want %h",
                     {bus.mult_enable, bus.acc_we, bus.acc_addr, bus.acc_clear},
                     {1'b0, exp_acc});
        else pass_cnt++;
        chk_cnt++;
        if ({bus.busy, bus.done, bus.cfg_err} !== 3'b100)
            $display("FAIL flush_ctl busy/done/err=%b want 100",
                     {bus.busy, bus.done, bus.cfg_err});
        else pass_cnt++;

        @(negedge clk);
        bus.start = start_in_done;
        #1;
        chk_cnt++;
        if ({bus.busy, bus.done, bus.cfg_err, bus.mult_enable, bus.acc_we} !== 5'b11000)
            $display("FAIL done_ctl busy/done/err/men/we=%b want 11000",
                     {bus.busy, bus.done, bus.cfg_err, bus.mult_enable, bus.acc_we});
        else pass_cnt++;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        bus.start = 1'b0;
        bus.stall = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.busy, bus.done, bus.cfg_err, bus.acc_we} !== 4'b0000)
            $display("FAIL %s busy/done/err/we=%b want 0000", tag,
                     {bus.busy, bus.done, bus.cfg_err, bus.acc_we});
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.cfg_s       = '0;
        bus.cfg_q       = '0;
        bus.cfg_p       = '0;
        bus.ifmap_valid = 1'b0;
        bus.stall       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_cnt++;
        if ({bus.filt_addr, bus.ifmap_addr, bus.mult_enable, bus.acc_we, bus.acc_addr,
             bus.acc_clear, bus.busy, bus.done, bus.cfg_err} !== '0)
            $display("FAIL reset_outputs got %h want 0",
                     {bus.filt_addr, bus.ifmap_addr, bus.mult_enable, bus.acc_we,
                      bus.acc_addr, bus.acc_clear, bus.busy, bus.done, bus.cfg_err});
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        check_idle("reset_release");
    endtask

    task automatic test_basic();
        drive_pass(3, 2, 2, -1, 0, 0, -1, 1'b0);
    endtask

    task automatic test_stall();
        drive_pass(3, 2, 2, 5, 3, 0, -1, 1'b0);
    endtask

    task automatic test_ifmap_wait();
        drive_pass(3, 2, 2, -1, 0, 4, -1, 1'b0);
    endtask

    task automatic test_boundary_legal();
        drive_pass(4, 4, 16, -1, 0, 0, -1, 1'b0);
        drive_pass(1, 1, 31, -1, 0, 0, -1, 1'b0);
    endtask

    task automatic test_illegal_cfg();
        int tbl [5][3] = '{'{3, 2, 0}, '{4, 5, 16}, '{3, 5, 18}, '{1, 17, 1}, '{0, 1, 1}};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.cfg_s = CW'(tbl[i][0]);
            bus.cfg_q = CW'(tbl[i][1]);
            bus.cfg_p = CW'(tbl[i][2]);
            bus.ifmap_valid = 1'b1;
            bus.stall = 1'b0;
            #1;
            chk_cnt++;
            if (bus.busy !== 1'b0)
                $display("FAIL illegal_idle[%0d] busy=%0b want 0", i, bus.busy);
            else pass_cnt++;
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            chk_cnt++;
            if ({bus.busy, bus.done, bus.cfg_err, bus.mult_enable, bus.acc_we} !== 5'b11100)
                $display("FAIL illegal_done[%0d] busy/done/err/men/we=%b want 11100", i,
                         {bus.busy, bus.done, bus.cfg_err, bus.mult_enable, bus.acc_we});
            else pass_cnt++;
            check_idle("illegal_after");
        end
    endtask

    task automatic test_reset_mid_pass();
        @(negedge clk);
        bus.start = 1'b1;
        bus.cfg_s = CW'(3);
        bus.cfg_q = CW'(2);
        bus.cfg_p = CW'(2);
        bus.ifmap_valid = 1'b1;
        bus.stall = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk_cnt++;
        if ({bus.mult_enable, bus.filt_addr, bus.acc_we} !== {1'b1, 8'd7, 1'b1})
            $display("FAIL pre_abort men/filt/we=%h want %h",
                     {bus.mult_enable, bus.filt_addr, bus.acc_we}, {1'b1, 8'd7, 1'b1});
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        chk_cnt++;
        if ({bus.filt_addr, bus.ifmap_addr, bus.mult_enable, bus.acc_we, bus.acc_addr,
             bus.acc_clear, bus.busy, bus.done, bus.cfg_err} !== '0)
            $display("FAIL abort_outputs got %h want 0",
                     {bus.filt_addr, bus.ifmap_addr, bus.mult_enable, bus.acc_we,
                      bus.acc_addr, bus.acc_clear, bus.busy, bus.done, bus.cfg_err});
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) check_idle("after_abort");
        drive_pass(3, 2, 2, -1, 0, 0, -1, 1'b0);
    endtask

    task automatic test_start_ignored();
        // start pulsed at op 3 and again in DONE; the next pass's first cycle
        // verifies the sequencer went back to idle
        drive_pass(3, 2, 2, -1, 0, 0, 3, 1'b1);
        drive_pass(2, 1, 3, -1, 0, 0, -1, 1'b0);
        check_idle("final_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_ifmap_wait();
        test_illegal_cfg();
        test_boundary_legal();
        test_reset_mid_pass();
        test_start_ignored();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/pe_mac_sequencer.md
Name: pe_mac_sequencer

Overview:
Per-PE controller that sequences the signed multiplier and psum accumulator through one sliding-window pass. It covers S filter taps × q channels × p filters. It generates scratchpad read addresses and the multiplier enable, then the delayed accumulator write controls. It sits between the PE's config/handshake logic and the spad + multiplier + adder datapath.

Parameters:
FILT_ADDR_W, 8, filter spad address width (max 256 entries)
IFMAP_ADDR_W, 4, ifmap spad address width (max 16 entries)
PSUM_ADDR_W, 5, psum spad address width (max 32 entries)
CNT_W, 5, width of cfg_s/cfg_q/cfg_p fields

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  begin a pass; sampled only in IDLE
cfg_s  in  CNT_W  filter row width S (taps)
cfg_q  in  CNT_W  channels per PE q
cfg_p  in  CNT_W  filters per PE p
ifmap_valid  in  1  ifmap spad holds current window
stall  in  1  freeze issue (e.g. psum readout in progress)
filt_addr  out  FILT_ADDR_W  filter spad read address
ifmap_addr  out  IFMAP_ADDR_W  ifmap spad read address
mult_enable  out  1  multiplier enable for the issued operand pair
acc_we  out  1  accumulate product into psum spad
acc_addr  out  PSUM_ADDR_W  psum spad entry to accumulate
acc_clear  out  1  with acc_we: write product alone (first term), ignore old psum
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse at end of pass
cfg_err  out  1  one-cycle pulse, concurrent with done, on illegal config

Behaviour:
- Reset: state=IDLE; all counters 0; all outputs 0. Reset mid-pass aborts immediately, with no done or acc_we afterwards.
- The multiplier captures on negedge. Its product is stable at the posedge after mult_enable. Accumulate controls therefore lag issue by exactly 1 cycle.
- States: IDLE, WAIT_IFMAP, RUN, FLUSH, DONE.
- IDLE: on start=1, latch cfg_s/q/p and check legality.
  - Legal → WAIT_IFMAP.
  - Illegal → DONE with cfg_err.
  - start in any other state is ignored.
- Illegal config means any field = 0, or S·q·p > 2^FILT_ADDR_W, or S·q > 2^IFMAP_ADDR_W, or p > 2^PSUM_ADDR_W.
- WAIT_IFMAP: → RUN at the posedge where ifmap_valid=1.
- RUN: one operation per cycle when stall=0. Loop order is f innermost (0..p-1), then c (0..q-1), then s (0..S-1).
  - filt_addr = linear op index (0..S·q·p-1).
  - ifmap_addr = s·q+c, incremented when f wraps.
  - issued psum address = f.
  - issued clear = (s==0 && c==0).
  - mult_enable = (state==RUN && !stall). These outputs are combinational from state and counters.
  - stall=1: counters hold, mult_enable=0, addresses hold.
  - Last op issued (stall=0, f=p-1, c=q-1, s=S-1) → FLUSH.
- acc_we, acc_addr and acc_clear are registered copies of mult_enable, issued psum address and issued clear. When acc_we=0, acc_addr and acc_clear are 0.
- FLUSH: single cycle. acc_we for the final op is asserted here. → DONE.
- DONE: done=1 for one cycle; cfg_err=1 if entered from the illegal-config path. → IDLE.
- Timing with no stall: N = S·q·p ops take N RUN cycles + 1 FLUSH + 1 DONE after RUN entry.
- The ifmap_valid deassert during RUN is ignored; the window is assumed held by the owner until done.
- Stall in FLUSH/DONE has no effect.
- start asserted in the same cycle as done is ignored; start is accepted only from the following IDLE cycle.

Test Plan:
- S=3,q=2,p=2, ifmap_valid=1, no stall → 12 consecutive mult_enable cycles.
  - filt_addr 0..11; ifmap_addr 0,0,1,1,2,2,3,3,4,4,5,5.
  - acc_addr 0,1,0,1,...; acc_clear only on ops 0,1.
  - acc_we trails mult_enable by 1; done 2 cycles after last mult_enable.
- Same config, stall=1 for 3 cycles at op 5 → mult_enable low 3 cycles, filt_addr holds 5; total RUN=15 cycles; sequence otherwise identical.
- ifmap_valid held low 4 cycles after start → busy=1, mult_enable=0 for those cycles; RUN begins the cycle after ifmap_valid rises.
- cfg_p=0 (and separately S=4,q=5,p=16 → 320 > 256) → no mult_enable/acc_we; done and cfg_err pulse together 1 cycle after the DONE transition; busy then 0.
- Reset asserted asynchronously at op 7 → all outputs 0 immediately, state IDLE, no done. A following start reruns from filt_addr 0.
- start pulsed during RUN, and again in the DONE cycle → both ignored; start in the next IDLE cycle starts a new pass.
